// File: rtl/coreboard1588_rtc_pkg.sv
// Shared types and parameter-derived constants for the RTC command arbiter.
package coreboard1588_rtc_pkg;

    localparam int NS_PER_SEC = 1000000000;

    typedef enum logic [1:0] {
        OP_GET = 2'b00,
        OP_SET = 2'b01,
        OP_INC = 2'b10,
        OP_RSV = 2'b11
    } rtc_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } arb_state_t;

    function automatic int calc_step(input int clock_frequency);
        return NS_PER_SEC / clock_frequency;
    endfunction

    // SET/INC may only issue while the live nanosecond count is strictly below this.
    function automatic logic [31:0] calc_guard_threshold(input int clock_frequency,
                                                         input int guard_ns);
        return 32'(NS_PER_SEC - calc_step(clock_frequency) - guard_ns);
    endfunction

endpackage

// File: rtl/coreboard1588_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after a rotating pointer.
module coreboard1588_rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 en_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
                found             = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && found) begin
            ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/coreboard1588_rtc_cmd_arbiter.sv
// Serialises RTC timeset/timeget/second_inc commands from several requesters,
// holding off SET/INC near nanosecond rollover in normal mode.
module coreboard1588_rtc_cmd_arbiter
    import coreboard1588_rtc_pkg::*;
#(
    parameter int C_NUM_REQ         = 2,
    parameter int C_CLOCK_FREQUENCY = 125000000,
    parameter int C_GUARD_NS        = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_NUM_REQ-1:0]    req_valid,
    output logic [C_NUM_REQ-1:0]    req_ready,
    input  logic [2*C_NUM_REQ-1:0]  req_op,
    input  logic [32*C_NUM_REQ-1:0] req_second,
    input  logic [32*C_NUM_REQ-1:0] req_nanosecond,
    output logic [C_NUM_REQ-1:0]    rsp_valid,
    output logic                    rsp_err,
    output logic [31:0]             rsp_second,
    output logic [31:0]             rsp_nanosecond,
    output logic                    busy,
    input  logic                    ctrl_rtc_mode,
    input  logic [31:0]             rtc_nanosecond,
    input  logic [31:0]             stat_second,
    input  logic [31:0]             stat_nanosecond,
    output logic                    ctrl_timeset,
    output logic                    ctrl_timeget,
    output logic                    ctrl_second_inc,
    output logic [31:0]             ctrl_second,
    output logic [31:0]             ctrl_nanosecond
);

    localparam int          IDX_W        = $clog2(C_NUM_REQ);
    localparam logic [31:0] GUARD_THRESH = calc_guard_threshold(C_CLOCK_FREQUENCY, C_GUARD_NS);

    arb_state_t           state_q, state_d;
    logic [C_NUM_REQ-1:0] grant, owner_q;
    logic [IDX_W-1:0]     grant_idx;
    logic                 arb_en, accept;
    rtc_op_t              op_q;
    logic [31:0]          set_sec_q, set_ns_q;
    logic                 timeset_q, timeset_d, timeget_q, timeget_d, inc_q, inc_d;
    logic [31:0]          ctrl_sec_q, ctrl_sec_d, ctrl_ns_q, ctrl_ns_d;
    logic [31:0]          rsp_sec_q, rsp_sec_d, rsp_ns_q, rsp_ns_d;

    assign arb_en = (state_q == ST_IDLE);
    assign accept = arb_en && (|req_valid);

    coreboard1588_rr_arbiter #(.N(C_NUM_REQ)) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept) state_d = ST_CHECK;
            ST_CHECK: begin
                if (op_q == OP_RSV)      state_d = ST_RESP;
                else if (op_q == OP_GET) state_d = ST_ISSUE;
                else if (ctrl_rtc_mode || (rtc_nanosecond < GUARD_THRESH))
                                         state_d = ST_ISSUE;
            end
            ST_ISSUE:   state_d = (op_q == OP_GET) ? ST_CAPTURE : ST_RESP;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Ctrl pulses are registered from state_d so they are high exactly in ISSUE.
    always_comb begin
        req_ready  = arb_en ? grant : '0;
        busy       = (state_q != ST_IDLE) || (|req_valid);
        rsp_valid  = (state_q == ST_RESP) ? owner_q : '0;
        rsp_err    = (state_q == ST_RESP) && (op_q == OP_RSV);
        timeset_d  = (state_d == ST_ISSUE) && (op_q == OP_SET);
        timeget_d  = (state_d == ST_ISSUE) && (op_q == OP_GET);
        inc_d      = (state_d == ST_ISSUE) && (op_q == OP_INC);
        ctrl_sec_d = timeset_d ? set_sec_q : ctrl_sec_q;
        ctrl_ns_d  = timeset_d ? set_ns_q  : ctrl_ns_q;
        rsp_sec_d  = (state_q == ST_CAPTURE) ? stat_second     : '0;
        rsp_ns_d   = (state_q == ST_CAPTURE) ? stat_nanosecond : '0;
    end

    // NOTE: the command latches are reset too, so an aborted command leaves no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= '0;
            op_q       <= OP_GET;
            set_sec_q  <= '0;
            set_ns_q   <= '0;
            timeset_q  <= 1'b0;
            timeget_q  <= 1'b0;
            inc_q      <= 1'b0;
            ctrl_sec_q <= '0;
            ctrl_ns_q  <= '0;
            rsp_sec_q  <= '0;
            rsp_ns_q   <= '0;
        end else begin
            if (accept) begin
                owner_q   <= grant;
                op_q      <= rtc_op_t'(req_op[2*grant_idx +: 2]);
                set_sec_q <= req_second[32*grant_idx +: 32];
                set_ns_q  <= req_nanosecond[32*grant_idx +: 32];
            end
            timeset_q  <= timeset_d;
            timeget_q  <= timeget_d;
            inc_q      <= inc_d;
            ctrl_sec_q <= ctrl_sec_d;
            ctrl_ns_q  <= ctrl_ns_d;
            rsp_sec_q  <= rsp_sec_d;
            rsp_ns_q   <= rsp_ns_d;
        end
    end

    assign ctrl_timeset    = timeset_q;
    assign ctrl_timeget    = timeget_q;
    assign ctrl_second_inc = inc_q;
    assign ctrl_second     = ctrl_sec_q;
    assign ctrl_nanosecond = ctrl_ns_q;
    assign rsp_second      = rsp_sec_q;
    assign rsp_nanosecond  = rsp_ns_q;

endmodule

// File: tb/tb_coreboard1588_rtc_cmd_arbiter.sv
// Directed bench for the RTC command arbiter (N=2, 125 MHz, 64 ns guard).
module tb_coreboard1588_rtc_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [3:0]  req_op;
    logic [63:0] req_second, req_nanosecond;
    logic        rsp_err, busy, ctrl_rtc_mode;
    logic [31:0] rsp_second, rsp_nanosecond;
    logic [31:0] rtc_nanosecond, stat_second, stat_nanosecond;
    logic        ctrl_timeset, ctrl_timeget, ctrl_second_inc;
    logic [31:0] ctrl_second, ctrl_nanosecond;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    coreboard1588_rtc_cmd_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_second      (req_second),
        .req_nanosecond  (req_nanosecond),
        .rsp_valid       (rsp_valid),
        .rsp_err         (rsp_err),
        .rsp_second      (rsp_second),
        .rsp_nanosecond  (rsp_nanosecond),
        .busy            (busy),
        .ctrl_rtc_mode   (ctrl_rtc_mode),
        .rtc_nanosecond  (rtc_nanosecond),
        .stat_second     (stat_second),
        .stat_nanosecond (stat_nanosecond),
        .ctrl_timeset    (ctrl_timeset),
        .ctrl_timeget    (ctrl_timeget),
        .ctrl_second_inc (ctrl_second_inc),
        .ctrl_second     (ctrl_second),
        .ctrl_nanosecond (ctrl_nanosecond)
    );

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_second = '0; req_nanosecond = '0;
        ctrl_rtc_mode = 1'b0; rtc_nanosecond = 32'd500000000;
        stat_second = 32'h5555_0000; stat_nanosecond = 32'h0000_5555;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl got %b want 000000000",
                     {req_ready, rsp_valid, rsp_err, busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc});
        end
        tests_run++;
        if ({rsp_second, rsp_nanosecond, ctrl_second, ctrl_nanosecond} !== 128'b0) begin
            tests_failed++;
            $display("FAIL reset_data got %h want 0", {rsp_second, rsp_nanosecond, ctrl_second, ctrl_nanosecond});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_get();
        @(negedge clk);
        req_op = 4'b0000; req_valid = 2'b01;
        #1;
        tests_run++;
        if ({req_ready, busy} !== 3'b011) begin
            tests_failed++; $display("FAIL get_accept got %b want 011", {req_ready, busy});
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        tests_run++;
        if ({busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL get_t1 got %b want 100000", {busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid});
        end
        @(negedge clk);
        stat_second = 32'hDEAD_0001; stat_nanosecond = 32'hDEAD_0002;
        #1;
        tests_run++;
        if ({ctrl_timeset, ctrl_timeget, ctrl_second_inc} !== 3'b010) begin
            tests_failed++;
            $display("FAIL get_pulse got %b want 010", {ctrl_timeset, ctrl_timeget, ctrl_second_inc});
        end
        @(negedge clk);
        stat_second = 32'h0000_1234; stat_nanosecond = 32'h0ABC_DEF0;
        #1;
        tests_run++;
        if ({ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL get_t3 got %b want 00000", {ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid});
        end
        @(negedge clk);
        stat_second = 32'hFFFF_FFFF; stat_nanosecond = 32'hFFFF_FFFF;
        #1;
        tests_run++;
        if ({rsp_valid, rsp_err, busy} !== 4'b0101) begin
            tests_failed++; $display("FAIL get_rsp got %b want 0101", {rsp_valid, rsp_err, busy});
        end
        tests_run++;
        if ({rsp_second, rsp_nanosecond} !== {32'h0000_1234, 32'h0ABC_DEF0}) begin
            tests_failed++;
            $display("FAIL get_data got %h want 000012340abcdef0", {rsp_second, rsp_nanosecond});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, busy} !== 3'b000) begin
            tests_failed++; $display("FAIL get_done got %b want 000", {rsp_valid, busy});
        end
    endtask

    task automatic test_set();
        @(negedge clk);
        req_op = 4'b0100; req_second = {32'h1234_5678, 32'h0}; req_nanosecond = {32'd100, 32'd0};
        req_valid = 2'b10;
        #1;
        tests_run++;
        if (req_ready !== 2'b10) begin
            tests_failed++; $display("FAIL set_accept got %b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00; req_second = '1; req_nanosecond = '1;
        #1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({ctrl_timeset, ctrl_timeget, ctrl_second_inc} !== 3'b100) begin
            tests_failed++;
            $display("FAIL set_pulse got %b want 100", {ctrl_timeset, ctrl_timeget, ctrl_second_inc});
        end
        tests_run++;
        if ({ctrl_second, ctrl_nanosecond} !== {32'h1234_5678, 32'd100}) begin
            tests_failed++;
            $display("FAIL set_value got %h want 1234567800000064", {ctrl_second, ctrl_nanosecond});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, rsp_err, ctrl_timeset, rsp_second, rsp_nanosecond} !== {2'b10, 1'b0, 1'b0, 64'h0}) begin
            tests_failed++;
            $display("FAIL set_rsp got %b %b %b %h want 10 0 0 0", rsp_valid, rsp_err, ctrl_timeset,
                     {rsp_second, rsp_nanosecond});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, busy, ctrl_second} !== {3'b000, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL set_hold got %b %h want 000 12345678", {rsp_valid, busy}, ctrl_second);
        end
    endtask

    task automatic test_guard();
        @(negedge clk);
        rtc_nanosecond = 32'd999999960; req_op = 4'b0010; req_valid = 2'b01;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL guard_accept got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) rtc_nanosecond = 32'd999999928;
            if (c == 4) rtc_nanosecond = 32'd999999927;
            #1;
            tests_run++;
            if ({busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid} !== 6'b100000) begin
                tests_failed++;
                $display("FAIL guard_hold_t%0d got %b want 100000", c,
                         {busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid});
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({ctrl_timeset, ctrl_timeget, ctrl_second_inc} !== 3'b001) begin
            tests_failed++;
            $display("FAIL guard_pulse got %b want 001", {ctrl_timeset, ctrl_timeget, ctrl_second_inc});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, rsp_err} !== 3'b010) begin
            tests_failed++; $display("FAIL guard_rsp got %b want 010", {rsp_valid, rsp_err});
        end
        rtc_nanosecond = 32'd500000000;
    endtask

    task automatic test_pps();
        @(negedge clk);
        ctrl_rtc_mode = 1'b1; rtc_nanosecond = 32'd999999990; req_op = 4'b1000; req_valid = 2'b10;
        #1;
        tests_run++;
        if (req_ready !== 2'b10) begin
            tests_failed++; $display("FAIL pps_accept got %b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        tests_run++;
        if ({ctrl_timeset, ctrl_timeget, ctrl_second_inc} !== 3'b001) begin
            tests_failed++;
            $display("FAIL pps_pulse got %b want 001", {ctrl_timeset, ctrl_timeget, ctrl_second_inc});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 2'b10) begin
            tests_failed++; $display("FAIL pps_rsp got %b want 10", rsp_valid);
        end
        ctrl_rtc_mode = 1'b0; rtc_nanosecond = 32'd500000000;
    endtask

    task automatic test_back_to_back();
        int         rem0, rem1, grants, resps, cyc;
        logic [1:0] owner, exp_grant;
        rem0 = 3; rem1 = 3; grants = 0; resps = 0; cyc = 0; owner = 2'b00;
        req_op = 4'b0000;
        while (resps < 6 && cyc < 100) begin
            @(negedge clk);
            req_valid = {rem1 > 0, rem0 > 0};
            #1;
            cyc++;
            if (req_ready !== 2'b00) begin
                exp_grant = grants[0] ? 2'b10 : 2'b01;
                tests_run++;
                if (req_ready !== exp_grant) begin
                    tests_failed++;
                    $display("FAIL rr_grant%0d got %b want %b", grants, req_ready, exp_grant);
                end
                owner = req_ready;
                if (req_ready[0]) rem0--;
                if (req_ready[1]) rem1--;
                grants++;
            end
            if (rsp_valid !== 2'b00) begin
                tests_run++;
                if (rsp_valid !== owner) begin
                    tests_failed++;
                    $display("FAIL rr_owner%0d got %b want %b", resps, rsp_valid, owner);
                end
                resps++;
            end
        end
        req_valid = 2'b00;
        tests_run++;
        if (resps != 6) begin
            tests_failed++; $display("FAIL rr_count got %0d responses want 6", resps);
        end
    endtask

    task automatic test_reserved();
        @(negedge clk);
        stat_second = 32'hCAFE_0001; stat_nanosecond = 32'hCAFE_0002;
        req_op = 4'b0011; req_valid = 2'b01;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL rsv_accept got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        tests_run++;
        if ({ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rsv_t1 got %b want 00000", {ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, rsp_err, ctrl_timeset, ctrl_timeget, ctrl_second_inc} !== 6'b011000) begin
            tests_failed++;
            $display("FAIL rsv_rsp got %b want 011000",
                     {rsp_valid, rsp_err, ctrl_timeset, ctrl_timeget, ctrl_second_inc});
        end
        tests_run++;
        if ({rsp_second, rsp_nanosecond} !== 64'h0) begin
            tests_failed++; $display("FAIL rsv_data got %h want 0", {rsp_second, rsp_nanosecond});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, rsp_err, busy} !== 4'b0) begin
            tests_failed++; $display("FAIL rsv_done got %b want 0000", {rsp_valid, rsp_err, busy});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_op = 4'b0001; req_second = {32'h0, 32'h0BAD_0000}; req_nanosecond = {32'h0, 32'd777};
        req_valid = 2'b01;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL rstmid_accept got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc,
             ctrl_second, ctrl_nanosecond} !== 73'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs got %b %h %h want 0", {req_ready, rsp_valid, rsp_err, busy,
                     ctrl_timeset, ctrl_timeget, ctrl_second_inc}, ctrl_second, ctrl_nanosecond);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid} !== 6'b0) begin
                tests_failed++;
                $display("FAIL rstmid_quiet%0d got %b want 000000", c,
                         {busy, ctrl_timeset, ctrl_timeget, ctrl_second_inc, rsp_valid});
            end
        end
        @(negedge clk);
        req_op = 4'b0000; req_valid = 2'b11;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL rstmid_ptr got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_get();
        test_set();
        test_guard();
        test_pps();
        test_back_to_back();
        test_reserved();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
